led_scan_driver: RTL

Downstream consumer of the 16x16 red/green pixel arrays produced by the pattern and game logic blocks. Scans the bicolour LED matrix one row at a time and drives row-select plus per-row column data to the GPIO header. Captures a full frame snapshot at frame start so the displayed image never tears mid-frame. Runs from the system clock; row timing comes from parameterised dwell and blanking counters.

---
 rtl/led_pkg.sv | 15 +
 rtl/led_row_timer.sv | 43 ++++
 rtl/led_scan_driver.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and constants for the LED matrix scan driver
package led_pkg;

  localparam int NUM_ROWS = 16;

  // [row][col], 1 = lit
  typedef logic [15:0][15:0] pixel_frame_t;

  typedef enum logic [1:0] {
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_t;

endpackage

// File: rtl/led_row_timer.sv
// rtl/led_row_timer.sv - load/terminal-count cycle counter for the scan FSM
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - synchronous active-high reset
//   restart_i - clear count to 0 (asserted on every state entry)
//   term_i    - terminal count (cycles in state minus one)
//   count_o   - current count
//   done_o    - high while count equals terminal
module led_row_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         restart_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         done_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // The FSM always leaves the state on done, so restart follows done and the
  // count can never run past the terminal value.
  always_comb begin
    count_d = count_q + W'(1);
    if (restart_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q == term_i);

endmodule

// File: rtl/led_scan_driver.sv
// rtl/led_scan_driver.sv - row-scanning driver for a 16x16 bicolour LED matrix
// Optional PWM brightness: define LED_SCAN_PWM_EN.
// Ports:
//   CLK, RST             - clock, synchronous active-high reset
//   RedPixels, GrnPixels - frame inputs, snapshotted at row-0 latch
//   brightness           - (LED_SCAN_PWM_EN only) duty in 1/16 steps
//   row_sel, row_en      - row address and row driver enable
//   red_col, grn_col     - column drives for row_sel
//   frame_start          - pulse on first DISPLAY cycle of row 0
module led_scan_driver
  import led_pkg::*;
#(
  parameter int DWELL_CYCLES   = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int COL_ACTIVE_LOW = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  pixel_frame_t RedPixels,
  input  pixel_frame_t GrnPixels,
`ifdef LED_SCAN_PWM_EN
  input  logic [3:0]   brightness,
`endif
  output logic [3:0]   row_sel,
  output logic         row_en,
  output logic [15:0]  red_col,
  output logic [15:0]  grn_col,
  output logic         frame_start
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] T_BLANK = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] T_DWELL = CW'(DWELL_CYCLES - 1);
  localparam logic [15:0]   COL_OFF = (COL_ACTIVE_LOW != 0) ? 16'hFFFF : 16'h0000;

  scan_state_t  state_q, state_d;
  logic [3:0]   row_q, row_d;
  logic [3:0]   row_sel_q, row_sel_d;
  logic         row_en_q, row_en_d;
  logic         fs_q, fs_d;
  logic [15:0]  red_q, red_d;
  logic [15:0]  grn_q, grn_d;
  pixel_frame_t fb_red_q, fb_grn_q;

  logic [CW-1:0] term;
  logic [CW-1:0] count;
  logic          done;
  logic          restart;
  logic          latch_row0;
  logic [15:0]   red_row;
  logic [15:0]   grn_row;
  logic          pwm_on;

  led_row_timer #(.W(CW)) u_timer (
    .clk_i     (CLK),
    .rst_i     (RST),
    .restart_i (restart),
    .term_i    (term),
    .count_o   (count),
    .done_o    (done)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    term    = T_BLANK;
    case (state_q)
      BLANK: begin
        term = T_BLANK;
        if (done) state_d = LATCH;
      end
      LATCH: begin
        term    = '0;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        term = T_DWELL;
        if (done) begin
          state_d = BLANK;
          row_d   = row_q + 4'd1;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // Every state is left after its timer expires, so a state change is
  // exactly a state entry.
  assign restart = (state_d != state_q);

`ifdef LED_SCAN_PWM_EN
  logic [3:0] bright_q, bright_d;
  logic [CW:0] cnt_next;
  logic [31:0] cnt_next32;

  // row_en is registered, so the duty test uses the count the timer will
  // hold in the cycle the new row_en is visible.
  always_comb begin
    bright_d   = (state_q == LATCH) ? brightness : bright_q;
    cnt_next   = restart ? '0 : ({1'b0, count} + (CW+1)'(1));
    cnt_next32 = 32'(cnt_next);
    pwm_on     = (cnt_next32[3:0] < bright_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bright_q <= '0;
    end else begin
      bright_q <= bright_d;
    end
  end
`else
  logic unused_count;
  assign unused_count = ^count;
  assign pwm_on = 1'b1;
`endif

  // Row 0 reads the live inputs while the snapshot is taken in the same
  // cycle; later rows read the snapshot so the frame cannot tear.
  assign latch_row0 = (state_q == LATCH) && (row_q == 4'd0);
  assign red_row    = latch_row0 ? RedPixels[row_q] : fb_red_q[row_q];
  assign grn_row    = latch_row0 ? GrnPixels[row_q] : fb_grn_q[row_q];

  // Outputs are computed from the next state so they line up with state_q.
  always_comb begin
    red_d     = COL_OFF;
    grn_d     = COL_OFF;
    row_sel_d = row_sel_q;
    row_en_d  = (state_d == DISPLAY) && pwm_on;
    fs_d      = latch_row0;
    if (state_q == LATCH) begin
      red_d = red_row ^ COL_OFF;
      grn_d = grn_row ^ COL_OFF;
    end else if (state_d == DISPLAY) begin
      red_d = red_q;
      grn_d = grn_q;
    end
    if (state_d == LATCH) begin
      row_sel_d = row_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= BLANK;
      row_q     <= '0;
      row_sel_q <= '0;
      row_en_q  <= 1'b0;
      fs_q      <= 1'b0;
      red_q     <= COL_OFF;
      grn_q     <= COL_OFF;
      fb_red_q  <= '0;
      fb_grn_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      row_sel_q <= row_sel_d;
      row_en_q  <= row_en_d;
      fs_q      <= fs_d;
      red_q     <= red_d;
      grn_q     <= grn_d;
      if (latch_row0) begin
        fb_red_q <= RedPixels;
        fb_grn_q <= GrnPixels;
      end
    end
  end

  assign row_sel     = row_sel_q;
  assign row_en      = row_en_q;
  assign red_col     = red_q;
  assign grn_col     = grn_q;
  assign frame_start = fs_q;

endmodule
